// File: rtl/combo_lock_fsm_param.sv
// Parametrised combination-lock controller: code entry, compare, code change,
// duress detection, failed-attempt lockout and inactivity timeout.
module combo_lock_fsm_param #(
    parameter int unsigned                       NUM_DIGITS     = 4,
    parameter int unsigned                       DIGIT_W        = 4,
    parameter int unsigned                       IDX_W          = 2,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]     RESET_CODE     = 16'h1234,
    parameter int unsigned                       MAX_TRIES      = 3,
    parameter int unsigned                       LOCKOUT_CYCLES = 1000,
    parameter int unsigned                       TIMEOUT_CYCLES = 5000
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             Open_Close,
    input  logic                             Validate,
    input  logic                             Change,
    input  logic [DIGIT_W-1:0]               Digit_In,
    output logic [2:0]                       Mode,
    output logic [IDX_W-1:0]                 Digit_Idx,
    output logic [NUM_DIGITS*DIGIT_W-1:0]    Entry_Buf,
    output logic                             Unlocked,
    output logic                             ALARM,
    output logic [IDX_W:0]                   Fail_Cnt
);

    localparam int unsigned CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int unsigned FC_W   = IDX_W + 1;
    localparam int unsigned TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LK_W   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LK_W-1:0]  LK_LAST  = LK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_TRIP  = FC_W'(MAX_TRIES - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_TRIES);

    localparam logic [2:0] S_LOCKED  = 3'd0;
    localparam logic [2:0] S_ENTER   = 3'd1;
    localparam logic [2:0] S_COMPARE = 3'd2;
    localparam logic [2:0] S_PASS    = 3'd3;
    localparam logic [2:0] S_DURESS  = 3'd4;
    localparam logic [2:0] S_FAIL    = 3'd5;
    localparam logic [2:0] S_LOCKOUT = 3'd6;
    localparam logic [2:0] S_SET     = 3'd7;

    localparam logic [2:0] MODE_LOCK    = 3'b000;
    localparam logic [2:0] MODE_ENTER   = 3'b001;
    localparam logic [2:0] MODE_PASS    = 3'b010;
    localparam logic [2:0] MODE_FAIL    = 3'b011;
    localparam logic [2:0] MODE_LOCKOUT = 3'b100;
    localparam logic [2:0] MODE_SET     = 3'b101;

    logic [2:0]        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [LK_W-1:0]   lk_q, lk_d;
    logic [IDX_W-1:0]  idx_d;
    logic [CODE_W-1:0] buf_d, wr_buf, rev_code;
    logic [FC_W-1:0]   fail_d;
    logic [2:0]        mode_d;
    logic              unlocked_d, alarm_d;

    // Stored code with digit order reversed (duress pattern)
    always_comb begin
        rev_code = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            rev_code[i*DIGIT_W +: DIGIT_W] = code_q[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
        end
    end

    // Entry buffer with Digit_In written into the current slot (slot 0 = MSD)
    always_comb begin
        wr_buf = Entry_Buf;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (Digit_Idx == IDX_W'(i)) begin
                wr_buf[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = Digit_In;
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        tmr_d   = tmr_q;
        lk_d    = lk_q;
        idx_d   = Digit_Idx;
        buf_d   = Entry_Buf;
        fail_d  = Fail_Cnt;

        case (state_q)
            S_LOCKED: begin
                if (Open_Close) begin
                    state_d = S_ENTER;
                    idx_d   = '0;
                    buf_d   = '0;
                    tmr_d   = '0;
                end
            end
            S_ENTER, S_SET: begin
                if (Change) begin
                    idx_d = '0;
                    buf_d = '0;
                    tmr_d = '0;
                end else if (Validate) begin
                    buf_d = wr_buf;
                    tmr_d = '0;
                    if (Digit_Idx == LAST_IDX) begin
                        if (state_q == S_ENTER) begin
                            state_d = S_COMPARE;
                        end else begin
                            code_d  = wr_buf;
                            state_d = S_LOCKED;
                        end
                    end else begin
                        idx_d = Digit_Idx + IDX_W'(1);
                    end
                end else if (tmr_q == TMR_LAST) begin
                    state_d = S_LOCKED;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_COMPARE: begin
                if (Entry_Buf == code_q) begin
                    state_d = S_PASS;
                    fail_d  = '0;
                end else if (Entry_Buf == rev_code) begin
                    state_d = S_DURESS;
                    fail_d  = '0;
                end else if (Fail_Cnt >= FC_TRIP) begin
                    state_d = S_LOCKOUT;
                    fail_d  = FC_MAX;
                    lk_d    = '0;
                end else begin
                    state_d = S_FAIL;
                    fail_d  = Fail_Cnt + FC_W'(1);
                end
            end
            S_PASS: begin
                if (Open_Close) begin
                    state_d = S_LOCKED;
                end else if (Change) begin
                    state_d = S_SET;
                    idx_d   = '0;
                    buf_d   = '0;
                    tmr_d   = '0;
                end
            end
            S_DURESS, S_FAIL: begin
                if (Open_Close) begin
                    state_d = S_LOCKED;
                end
            end
            S_LOCKOUT: begin
                if (lk_q == LK_LAST) begin
                    state_d = S_LOCKED;
                    fail_d  = '0;
                end else begin
                    lk_d = lk_q + LK_W'(1);
                end
            end
            default: begin
                state_d = S_LOCKED;
            end
        endcase

        // Every entry into LOCKED leaves a clean buffer and index
        if (state_d == S_LOCKED && state_q != S_LOCKED) begin
            idx_d = '0;
            buf_d = '0;
            tmr_d = '0;
        end
    end

    // Output decode from the next state so the registered outputs track the state register
    always_comb begin
        mode_d     = MODE_LOCK;
        unlocked_d = 1'b0;
        alarm_d    = 1'b0;
        case (state_d)
            S_ENTER, S_COMPARE: mode_d = MODE_ENTER;
            S_PASS: begin
                mode_d     = MODE_PASS;
                unlocked_d = 1'b1;
            end
            S_DURESS: begin
                mode_d     = MODE_PASS;
                unlocked_d = 1'b1;
                alarm_d    = 1'b1;
            end
            S_FAIL:    mode_d = MODE_FAIL;
            S_LOCKOUT: mode_d = MODE_LOCKOUT;
            S_SET:     mode_d = MODE_SET;
            default:   mode_d = MODE_LOCK;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_LOCKED;
            code_q    <= RESET_CODE;
            tmr_q     <= '0;
            lk_q      <= '0;
            Digit_Idx <= '0;
            Entry_Buf <= '0;
            Fail_Cnt  <= '0;
            Mode      <= MODE_LOCK;
            Unlocked  <= 1'b0;
            ALARM     <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            tmr_q     <= tmr_d;
            lk_q      <= lk_d;
            Digit_Idx <= idx_d;
            Entry_Buf <= buf_d;
            Fail_Cnt  <= fail_d;
            Mode      <= mode_d;
            Unlocked  <= unlocked_d;
            ALARM     <= alarm_d;
        end
    end

endmodule

// File: tb/tb_combo_lock_fsm_param.sv
// Directed self-checking bench for combo_lock_fsm_param with default parameters.
module tb_combo_lock_fsm_param;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Open_Close, Validate, Change;
    logic [3:0]  Digit_In;
    logic [2:0]  Mode;
    logic [1:0]  Digit_Idx;
    logic [15:0] Entry_Buf;
    logic        Unlocked, ALARM;
    logic [2:0]  Fail_Cnt;

    int checks   = 0;
    int failures = 0;

    combo_lock_fsm_param dut (
        .CLK       (CLK),
        .RST       (RST),
        .Open_Close(Open_Close),
        .Validate  (Validate),
        .Change    (Change),
        .Digit_In  (Digit_In),
        .Mode      (Mode),
        .Digit_Idx (Digit_Idx),
        .Entry_Buf (Entry_Buf),
        .Unlocked  (Unlocked),
        .ALARM     (ALARM),
        .Fail_Cnt  (Fail_Cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle input pulse; returns at the negedge after the consuming posedge
    task automatic drive(input logic oc, input logic va, input logic ch, input logic [3:0] d);
        Open_Close = oc;
        Validate   = va;
        Change     = ch;
        Digit_In   = d;
        @(negedge CLK);
        Open_Close = 1'b0;
        Validate   = 1'b0;
        Change     = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, c[15-4*i -: 4]);
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic reset_pulse();
        RST = 1'b1;
        #1;
        check("rst_mode", 32'(Mode), 32'd0);
        check("rst_idx", 32'(Digit_Idx), 32'd0);
        check("rst_buf", 32'(Entry_Buf), 32'h0);
        check("rst_unl", 32'(Unlocked), 32'd0);
        check("rst_alarm", 32'(ALARM), 32'd0);
        check("rst_fail", 32'(Fail_Cnt), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    int cnt;

    initial begin
        RST = 1'b1;
        Open_Close = 1'b0;
        Validate   = 1'b0;
        Change     = 1'b0;
        Digit_In   = 4'h0;
        @(negedge CLK);
        @(negedge CLK);
        reset_pulse();

        // 1: correct code
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        check("t1_enter_mode", 32'(Mode), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 4'h1);
        check("t1_idx1", 32'(Digit_Idx), 32'd1);
        check("t1_buf1", 32'(Entry_Buf), 32'h1000);
        drive(1'b0, 1'b1, 1'b0, 4'h2);
        drive(1'b0, 1'b1, 1'b0, 4'h3);
        drive(1'b0, 1'b1, 1'b0, 4'h4);
        check("t1_cmp_unl", 32'(Unlocked), 32'd0);
        check("t1_cmp_buf", 32'(Entry_Buf), 32'h1234);
        check("t1_cmp_idx", 32'(Digit_Idx), 32'd3);
        tick();
        check("t1_pass_mode", 32'(Mode), 32'd2);
        check("t1_pass_unl", 32'(Unlocked), 32'd1);
        check("t1_pass_alarm", 32'(ALARM), 32'd0);
        check("t1_pass_fail", 32'(Fail_Cnt), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        check("t1_relock", 32'(Mode), 32'd0);
        check("t1_relock_buf", 32'(Entry_Buf), 32'h0);

        // 2: reversed code -> duress
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        enter_code(16'h4321);
        tick();
        check("t2_mode", 32'(Mode), 32'd2);
        check("t2_unl", 32'(Unlocked), 32'd1);
        check("t2_alarm", 32'(ALARM), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        check("t2_lock_mode", 32'(Mode), 32'd0);
        check("t2_lock_alarm", 32'(ALARM), 32'd0);
        check("t2_lock_unl", 32'(Unlocked), 32'd0);

        // 3: three failures -> lockout of exactly 1000 cycles
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 4'h0);
            enter_code(16'h5555);
            tick();
            if (k < 3) begin
                check("t3_fail_mode", 32'(Mode), 32'd3);
                check("t3_fail_cnt", 32'(Fail_Cnt), 32'(k));
                drive(1'b1, 1'b0, 1'b0, 4'h0);
            end
        end
        check("t3_lockout_mode", 32'(Mode), 32'd4);
        check("t3_lockout_cnt", 32'(Fail_Cnt), 32'd3);
        cnt = 1;
        while (cnt < 1100) begin
            drive((cnt % 100) == 0, (cnt % 7) == 0, 1'b0, 4'h1);
            if (Mode == 3'd4) cnt++;
            else break;
        end
        check("t3_lockout_len", 32'(cnt), 32'd1000);
        check("t3_after_mode", 32'(Mode), 32'd0);
        check("t3_after_fail", 32'(Fail_Cnt), 32'd0);

        // 4: change code to 9901
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        enter_code(16'h1234);
        tick();
        check("t4_pass", 32'(Mode), 32'd2);
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        check("t4_set_mode", 32'(Mode), 32'd5);
        check("t4_set_idx", 32'(Digit_Idx), 32'd0);
        enter_code(16'h9901);
        check("t4_set_done", 32'(Mode), 32'd0);
        check("t4_set_buf", 32'(Entry_Buf), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        enter_code(16'h1234);
        tick();
        check("t4_old_fails", 32'(Mode), 32'd3);
        check("t4_old_cnt", 32'(Fail_Cnt), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        enter_code(16'h9901);
        tick();
        check("t4_new_pass", 32'(Mode), 32'd2);
        check("t4_new_cnt", 32'(Fail_Cnt), 32'd0);

        // 5: reset restores 1234, then an abandoned SET times out
        @(negedge CLK);
        reset_pulse();
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        enter_code(16'h1234);
        tick();
        check("t5_pass", 32'(Mode), 32'd2);
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        drive(1'b0, 1'b1, 1'b0, 4'h7);
        drive(1'b0, 1'b1, 1'b0, 4'h7);
        check("t5_idx", 32'(Digit_Idx), 32'd2);
        check("t5_set_mode", 32'(Mode), 32'd5);
        cnt = 0;
        while (cnt < 5200) begin
            tick();
            cnt++;
            if (Mode == 3'd0) break;
        end
        check("t5_timeout_len", 32'(cnt), 32'd5000);
        check("t5_timeout_mode", 32'(Mode), 32'd0);
        check("t5_timeout_buf", 32'(Entry_Buf), 32'h0);
        check("t5_timeout_fail", 32'(Fail_Cnt), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        enter_code(16'h1234);
        tick();
        check("t5_code_kept", 32'(Mode), 32'd2);

        // 6: set code 9901, restart priority, reset mid-entry
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        enter_code(16'h9901);
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        drive(1'b0, 1'b1, 1'b0, 4'h5);
        drive(1'b0, 1'b1, 1'b0, 4'h6);
        check("t6_idx2", 32'(Digit_Idx), 32'd2);
        check("t6_buf2", 32'(Entry_Buf), 32'h5600);
        drive(1'b0, 1'b1, 1'b1, 4'h8);
        check("t6_chg_idx", 32'(Digit_Idx), 32'd0);
        check("t6_chg_buf", 32'(Entry_Buf), 32'h0);
        check("t6_chg_mode", 32'(Mode), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 4'h3);
        check("t6_buf_re", 32'(Entry_Buf), 32'h3000);
        reset_pulse();
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        enter_code(16'h1234);
        tick();
        check("t6_code_restored", 32'(Mode), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
